// File: rtl/aes_inv_iter.sv
// aes_inv_iter: iterative AES-128 decryption (FIPS-197 InvCipher), one inverse round per cycle.
// Key expansion runs forward for 10 cycles, then 10 inverse rounds rewind the key schedule.
// Optional feature: define AES_DEC_KEYCACHE_EN to cache K0/K10 and skip expansion on a key hit.

// GF(2^8) multiplicative inverse (0 maps to 0), computed as a^254.
module aes_gf_inv (
   input  logic [7:0] a,
   output logic [7:0] y
);
   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = x;
      for (int i = 0; i < 8; i++) begin
         if (z[i]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   logic [7:0] a2, a3, a6, a12, a15, a30, a60, a120, a240, a252;
   assign a2   = gmul(a, a);
   assign a3   = gmul(a2, a);
   assign a6   = gmul(a3, a3);
   assign a12  = gmul(a6, a6);
   assign a15  = gmul(a12, a3);
   assign a30  = gmul(a15, a15);
   assign a60  = gmul(a30, a30);
   assign a120 = gmul(a60, a60);
   assign a240 = gmul(a120, a120);
   assign a252 = gmul(a240, a12);
   assign y    = gmul(a252, a2);
endmodule

// Forward S-box: inverse followed by the affine transform.
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   logic [7:0] b;
   aes_gf_inv u_inv (.a(a), .y(b));
   assign y = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]}
              ^ 8'h63;
endmodule

// Inverse S-box: inverse affine transform followed by the field inverse.
module aes_inv_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);
   logic [7:0] t;
   assign t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
   aes_gf_inv u_inv (.a(t), .y(y));
endmodule

module aes_inv_iter (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] C,
   input  logic [127:0] K,
   output logic [127:0] P,
   output logic         valid,
   output logic         busy
);
   typedef enum logic [1:0] {StIdle, StKexp, StDec} st_e;

   st_e          st_q;
   logic [127:0] blk_q;
   logic [127:0] key_q;
   // Rcon index: counts 1..10 during expansion, then r+1 = 10..1 during decryption.
   logic [3:0]   rnd_q;

   logic         hit;
   logic [127:0] hit_k10;

   function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] z);
      logic [7:0] p;
      logic [7:0] t;
      p = 8'h00;
      t = x;
      for (int i = 0; i < 8; i++) begin
         if (z[i]) p = p ^ t;
         t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] idx);
      unique case (idx)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   function automatic logic [127:0] inv_mix(input logic [127:0] s);
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
         o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
         o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
         o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end
      return o;
   endfunction

   // Key schedule: the four forward S-boxes serve both directions; only their input differs.
   logic [31:0]  w0, w1, w2, w3, sub_in, rot_w, sub_w, rc_w;
   logic [31:0]  f0, f1, f2, f3, i3;
   logic [127:0] key_fwd, key_inv;

   assign w0     = key_q[127:96];
   assign w1     = key_q[95:64];
   assign w2     = key_q[63:32];
   assign w3     = key_q[31:0];
   assign i3     = w3 ^ w2;
   assign sub_in = (st_q == StDec) ? i3 : w3;
   assign rot_w  = {sub_in[23:0], sub_in[31:24]};
   assign rc_w   = {rcon(rnd_q), 24'h0};

   for (genvar j = 0; j < 4; j++) begin : g_sb
      aes_sbox u_sb (.a(rot_w[31-8*j -: 8]), .y(sub_w[31-8*j -: 8]));
   end

   assign f0      = w0 ^ sub_w ^ rc_w;
   assign f1      = w1 ^ f0;
   assign f2      = w2 ^ f1;
   assign f3      = w3 ^ f2;
   assign key_fwd = {f0, f1, f2, f3};
   assign key_inv = {w0 ^ sub_w ^ rc_w, w1 ^ w0, w2 ^ w1, i3};

   // Inverse round: InvShiftRows is pure wiring into the 16 inverse S-boxes.
   logic [127:0] isb, ark, round_out;
   for (genvar i = 0; i < 16; i++) begin : g_isb
      localparam int Src = 4 * (((i / 4) - (i % 4) + 4) % 4) + (i % 4);
      aes_inv_sbox u_isb (.a(blk_q[127-8*Src -: 8]), .y(isb[127-8*i -: 8]));
   end

   assign ark       = isb ^ key_inv;
   assign round_out = (rnd_q == 4'd1) ? ark : inv_mix(ark);
   assign busy      = (st_q != StIdle);

`ifdef AES_DEC_KEYCACHE_EN
   logic [127:0] cache_k0_q;
   logic [127:0] cache_k10_q;
   logic         cache_vld_q;

   assign hit     = cache_vld_q && (K == cache_k0_q);
   assign hit_k10 = cache_k10_q;

   // Cache: remember the key on a miss, publish K10 once expansion finishes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cache_k0_q  <= '0;
         cache_k10_q <= '0;
         cache_vld_q <= 1'b0;
      end else if ((st_q == StIdle) && start && !hit) begin
         cache_k0_q  <= K;
         cache_vld_q <= 1'b0;
      end else if ((st_q == StKexp) && (rnd_q == 4'd10)) begin
         cache_k10_q <= key_fwd;
         cache_vld_q <= 1'b1;
      end
   end
`else
   assign hit     = 1'b0;
   assign hit_k10 = '0;
`endif

   // Main FSM: idle, forward key expansion, inverse rounds; P/valid registered on the last round.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q  <= StIdle;
         blk_q <= '0;
         key_q <= '0;
         rnd_q <= 4'd0;
         P     <= '0;
         valid <= 1'b0;
      end else begin
         valid <= 1'b0;
         unique case (st_q)
            StIdle: begin
               if (start) begin
                  if (hit) begin
                     blk_q <= C ^ hit_k10;
                     key_q <= hit_k10;
                     rnd_q <= 4'd10;
                     st_q  <= StDec;
                  end else begin
                     blk_q <= C;
                     key_q <= K;
                     rnd_q <= 4'd1;
                     st_q  <= StKexp;
                  end
               end
            end
            StKexp: begin
               key_q <= key_fwd;
               if (rnd_q == 4'd10) begin
                  blk_q <= blk_q ^ key_fwd;
                  st_q  <= StDec;
               end else begin
                  rnd_q <= rnd_q + 4'd1;
               end
            end
            StDec: begin
               key_q <= key_inv;
               blk_q <= round_out;
               if (rnd_q == 4'd1) begin
                  P     <= round_out;
                  valid <= 1'b1;
                  st_q  <= StIdle;
               end else begin
                  rnd_q <= rnd_q - 4'd1;
               end
            end
            default: st_q <= StIdle;
         endcase
      end
   end
endmodule

// File: tb/tb_aes_inv_iter.sv
// Bench for aes_inv_iter: FIPS-197 vectors, back-to-back, mid-operation reset, key cache
// (when AES_DEC_KEYCACHE_EN is defined) and random loopback through a byte-level AES encrypt model.
module tb_aes_inv_iter;
`ifdef AES_DEC_KEYCACHE_EN
   localparam bit CacheEn = 1'b1;
`else
   localparam bit CacheEn = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] C, K;
   logic [127:0] P;
   logic         valid, busy;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0]   sbox [256];
   bit           mc_v;
   logic [127:0] mc_k;

   aes_inv_iter dut (
      .clk(clk), .rst(rst), .start(start), .C(C), .K(K), .P(P), .valid(valid), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // S-box table from the 3-generator walk of GF(2^8)*.
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ xt(p);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox[0] = 8'h63;
   endtask

   function automatic logic [127:0] encrypt(input logic [127:0] pt, input logic [127:0] key);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [31:0]  w [44];
      logic [7:0]   rc;
      logic [31:0]  tmp;
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] o;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]}
                  ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int rd = 1; rd <= 10; rd++) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[4*c+r] = sbox[s[4*((c+r)%4)+r]];
         if (rd != 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
               t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[4*rd + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   task automatic start_op(input logic [127:0] c, input logic [127:0] k);
      C = c;
      K = k;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Counts cycles after the accepting edge until valid; optionally pokes a stray start.
   task automatic wait_valid(input int spur, output int cyc, output bit busy_ok);
      cyc = 0;
      busy_ok = 1'b1;
      while (cyc < 60) begin
         @(posedge clk);
         #1 start = 1'b0;
         cyc++;
         if (valid) break;
         if (!busy) busy_ok = 1'b0;
         if (cyc == spur) begin
            C = {$urandom, $urandom, $urandom, $urandom};
            start = 1'b1;
         end
      end
   endtask

   task automatic run_op(input string tag, input logic [127:0] c, input logic [127:0] k,
                         input logic [127:0] pt, input int spur, output int exp_lat);
      int cyc;
      bit bok;
      bit hit;
      hit = CacheEn && mc_v && (k == mc_k);
      exp_lat = hit ? 10 : 20;
      start_op(c, k);
      wait_valid(spur, cyc, bok);
      check_eq({tag, " latency"}, 128'(cyc), 128'(exp_lat));
      check_eq({tag, " P"}, P, pt);
      check_eq({tag, " busy while running"}, 128'(bok), 128'(1));
      check_eq({tag, " busy at valid"}, 128'(busy), 128'(0));
      if (CacheEn && !hit) begin
         mc_v = 1'b1;
         mc_k = k;
      end
   endtask

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;

   initial begin
      int lat, lat2, nv;
      time t1, t2;
      logic [127:0] rk, rp, prev_k;
      build_sbox();
      mc_v = 1'b0;
      mc_k = '0;
      rst = 1'b1;
      start = 1'b0;
      C = '0;
      K = '0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset P", P, 128'h0);
      check_eq("reset valid", 128'(valid), 128'(0));
      check_eq("reset busy", 128'(busy), 128'(0));
      @(negedge clk) rst = 1'b0;
      @(negedge clk);

      run_op("fips C.1", C1, K1, P1, 0, lat);
      @(posedge clk);
      #1 check_eq("C.1 valid one cycle", 128'(valid), 128'(0));

      run_op("fips B", CB, KB, PB, 0, lat);

      // Back-to-back: second start issued in the valid cycle, stray start mid-flight.
      @(negedge clk);
      run_op("b2b first", C1, K1, P1, 0, lat);
      t1 = $time;
      run_op("b2b second", C1, K1, P1, 5, lat2);
      t2 = $time;
      check_eq("b2b valid gap", 128'((t2 - t1) / 10), 128'(lat2 + 1));
      nv = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk);
         #1 if (valid) nv++;
      end
      check_eq("stray start no extra valid", 128'(nv), 128'(0));

      // Reset in the middle of an operation.
      @(negedge clk);
      start_op(CB, KB);
      repeat (12) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      mc_v = 1'b0;
      #1;
      check_eq("mid-rst P", P, 128'h0);
      check_eq("mid-rst valid", 128'(valid), 128'(0));
      check_eq("mid-rst busy", 128'(busy), 128'(0));
      @(negedge clk) rst = 1'b0;
      nv = 0;
      for (int i = 0; i < 25; i++) begin
         @(posedge clk);
         #1 if (valid) nv++;
      end
      check_eq("mid-rst no valid", 128'(nv), 128'(0));

      // Same key twice then a new key: exercises the cache when it is built in.
      @(negedge clk);
      run_op("post-rst C.1", C1, K1, P1, 0, lat);
      run_op("repeat key C.1", C1, K1, P1, 0, lat);
      run_op("new key B", CB, KB, PB, 0, lat);

      // Loopback of random blocks through the encrypt model.
      prev_k = KB;
      for (int n = 0; n < 1000; n++) begin
         rk = ($urandom_range(0, 3) == 0) ? prev_k : {$urandom, $urandom, $urandom, $urandom};
         rp = {$urandom, $urandom, $urandom, $urandom};
         run_op("loopback", encrypt(rp, rk), rk, rp, 0, lat);
         prev_k = rk;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/aes_inv_iter.md
# aes_inv_iter

Iterative AES-128 decryption core: accepts a 128-bit ciphertext and 128-bit cipher key, and returns the plaintext after a fixed number of cycles. It is the receive-side counterpart of the team's pipelined AES-128 encryptor and produces FIPS-197 InvCipher results bit-exactly. One inverse round is computed per cycle, which trades throughput for area. It sits behind the encryptor in loopback tests and in the decrypt path of the crypto subsystem.

## Interface
- No parameters. Rounds are fixed at 10 (AES-128).
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  request. Sampled only in IDLE.
- C  in  128  ciphertext. Sampled with start.
- K  in  128  cipher key (round key 0). Sampled with start.
- P  out  128  plaintext. Registered; holds its value until the next completion.
- valid  out  1  one-cycle pulse; P is new in the same cycle.
- busy  out  1  high in every state other than IDLE.

## Operation
- Byte order follows FIPS-197: bits [127:120] are byte 0; the state is column-major.
- FSM has three states: IDLE, KEXP, DEC.
- **IDLE:** on start, latch state=C and key=K, set rcon index=1, go to KEXP.
- **KEXP (10 cycles):**
  - Each cycle advances key one step through the forward key schedule: RotWord, SubWord, Rcon 01,02,04,08,10,20,40,80,1B,36.
  - On the 10th cycle, key becomes K10 and state becomes state^K10 (the next-key value is used combinationally).
  - Then go to DEC with round counter r=9.
- **DEC (10 cycles, r=9..0):**
  - Each cycle derives Kr from K(r+1) with the inverse key schedule:
    - w3'=w3^w2, w2'=w2^w1, w1'=w1^w0
    - w0'=w0^SubWord(RotWord(w3'))^Rcon[r+1]
  - Each cycle computes state=InvMixColumns(InvSubBytes(InvShiftRows(state))^Kr).
  - InvMixColumns is omitted when r=0.
  - At r=0, register the result into P, pulse valid, go to IDLE.
- Inverse S-box: separate combinational submodule, 16 instances. Forward S-box: 4 instances for the key schedule.
- Arithmetic is GF(2^8) with polynomial 0x11B. InvMixColumns coefficients are 0E, 0B, 0D, 09.
- start while busy: ignored; no queuing.
- start in the cycle valid is high: FSM is already in IDLE, so the request is accepted.
- rst at any time: FSM goes to IDLE, P=0, valid=0, busy=0. Any in-flight operation is discarded.

## Timing
- Reset values: P=128'h0, valid=0, busy=0.
- Start accepted at edge E0.
- busy is high from E0 through E20.
- valid and the new P appear after edge E20, so latency is 20 cycles start-to-valid.
- Throughput: one block per 21 cycles. A start issued during the valid cycle gives back-to-back operation.
- valid is high for exactly one cycle per accepted start.

## Configuration
- **AES_DEC_KEYCACHE_EN defined:**
  - Registers cached K0, cached K10 and a cache-valid flag. All three are cleared by rst.
  - On completion of KEXP, the cache is loaded.
  - On start with cache-valid=1 and K==cached K0, KEXP is skipped. The FSM loads state=C^cachedK10 and key=cachedK10, and goes to DEC directly.
  - Latency in the cache-hit case is 10 cycles.
  - A cache miss behaves as without the macro and refreshes the cache.
- **Undefined:** no cache registers exist, and every operation takes 20 cycles.

## Test plan
- **FIPS-197 C.1:** K=000102030405060708090a0b0c0d0e0f, C=69c4e0d86a7b0430d8cdb78070b4c55a -> P=00112233445566778899aabbccddeeff, valid 20 cycles after start, one-cycle pulse.
- **FIPS-197 B:** K=2b7e151628aed2a6abf7158809cf4f3c, C=3925841d02dc09fbdc118597196a0b32 -> P=3243f6a8885a308d313198a2e0370734.
- **Back-to-back:** start re-asserted in the valid cycle with the C.1 vectors -> second valid exactly 21 cycles after the first. A start pulse at cycle 5 of busy is ignored, giving no extra valid.
- **Reset mid-operation:** rst at cycle 12 after start -> P=0, valid=0, busy=0 immediately. No valid follows. A new start then completes correctly.
- **Cache (macro defined):** two C.1 decrypts with the same K -> latencies 20 then 10, and both P correct. A third decrypt with the B key -> latency 20.
- **Loopback:** 1000 random K/P pairs through the encryptor, then through this block -> output equals the original P every time.
